// File: rtl/huffman_pkg.sv
// huffman_pkg: shared constants, state encoding and helpers for the symbol
// frequency counter that feeds the Huffman tree builder.
//   NUM_SYMBOLS : number of countable symbols (7-bit alphabet)
//   COUNT_W     : width of each per-symbol count and of the frame total
//   COUNT_SAT   : per-symbol ceiling; 16'hFFFF is reserved as the tree
//                 builder's end sentinel, so a count may never reach it
//   TOTAL_SAT   : ceiling of the frame total
package huffman_pkg;

  localparam int DATA_W      = 8;
  localparam int SYM_W       = 7;
  localparam int NUM_SYMBOLS = 128;
  localparam int COUNT_W     = 16;

  localparam logic [COUNT_W-1:0] COUNT_SAT = 16'hFFFE;
  localparam logic [COUNT_W-1:0] TOTAL_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    COUNT     = 3'd2,
    START     = 3'd3,
    WAIT_TREE = 3'd4
  } state_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic [COUNT_W-1:0] lim);
    return (v == lim) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/freq_count_if.sv
// freq_count_if: byte stream into the frequency counter.
//   data_in    : offered byte (bit 7 set marks a byte that is not countable)
//   data_valid : source offers data_in/data_last this cycle
//   data_last  : offered byte closes the frame
//   data_ready : counter accepts this cycle
// Handshake: a byte (with its data_last) is transferred on a rising clk edge
// where data_valid && data_ready are both high; nothing else has any effect.
// data_ready depends only on the counter state, never on data_valid.
interface freq_count_if;
  import huffman_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;

  modport master (output data_in, output data_valid, output data_last,
                  input  data_ready);
  modport slave  (input  data_in, input  data_valid, input  data_last,
                  output data_ready);
endinterface

// File: rtl/freq_count.sv
// freq_count: counts occurrences of each 7-bit symbol in a byte frame, then
// hands off to the Huffman tree builder with a one-cycle start pulse and
// holds the counts until the builder signals completion.
// Ports:
//   clk, reset         : clock; asynchronous active-low reset
//   bus (slave)        : byte stream (data_in/data_valid/data_last/data_ready)
//   build_tree_finish  : builder done flag; only its rising edge matters
//   curr_count         : per-symbol counts, index = data_in[6:0]
//   total_count        : countable bytes seen in the frame (saturating)
//   build_tree_start   : one-cycle pulse to the tree builder
//   busy               : high whenever the FSM is not in IDLE
//   invalid_seen       : sticky, frame contained a byte with bit 7 set
//   empty_err          : sticky, frame ended without any countable byte
//   state_dbg          : current FSM state
module freq_count
  import huffman_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  freq_count_if.slave                         bus,
  input  logic                                build_tree_finish,
  output logic [NUM_SYMBOLS-1:0][COUNT_W-1:0] curr_count,
  output logic [COUNT_W-1:0]                  total_count,
  output logic                                build_tree_start,
  output logic                                busy,
  output logic                                invalid_seen,
  output logic                                empty_err,
  output state_t                              state_dbg
);

  state_t           state;
  state_t           state_next;
  logic             ready;
  logic             accept;
  logic             countable;
  logic             finish_q;
  logic             finish_rise;
  logic [SYM_W-1:0] sym;

  assign accept      = ready && bus.data_valid;
  assign countable   = accept && !bus.data_in[DATA_W-1];
  assign sym         = bus.data_in[SYM_W-1:0];
  // The builder may leave its done flag high across frames, so only a fresh
  // low-to-high transition releases WAIT_TREE.
  assign finish_rise = build_tree_finish && !finish_q;

  assign bus.data_ready = ready;
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      finish_q <= 1'b0;
    end else begin
      state    <= state_next;
      finish_q <= build_tree_finish;
    end
  end

  always_comb begin
    state_next       = state;
    ready            = 1'b0;
    build_tree_start = 1'b0;
    case (state)
      IDLE: begin
        // The offered byte is left pending; it is taken once in COUNT.
        if (bus.data_valid) state_next = CLEAR;
      end
      CLEAR: begin
        state_next = COUNT;
      end
      COUNT: begin
        ready = 1'b1;
        if (accept && bus.data_last) begin
          // The closing byte itself may be the only countable one.
          if ((total_count != '0) || countable) state_next = START;
          else                                  state_next = IDLE;
        end
      end
      START: begin
        build_tree_start = 1'b1;
        state_next       = WAIT_TREE;
      end
      WAIT_TREE: begin
        if (finish_rise) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curr_count   <= '0;
      total_count  <= '0;
      invalid_seen <= 1'b0;
      empty_err    <= 1'b0;
    end else if (state == CLEAR) begin
      curr_count   <= '0;
      total_count  <= '0;
      invalid_seen <= 1'b0;
      empty_err    <= 1'b0;
    end else begin
      if (countable) begin
        curr_count[sym] <= sat_inc(curr_count[sym], COUNT_SAT);
        total_count     <= sat_inc(total_count, TOTAL_SAT);
      end
      if (accept && bus.data_in[DATA_W-1]) invalid_seen <= 1'b1;
      if (accept && bus.data_last && !countable && (total_count == '0))
        empty_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_count.sv
// tb_freq_count: directed checks of the frequency counter.
module tb_freq_count;
  import huffman_pkg::*;

  // clock / reset
  logic clk               = 1'b0;
  logic reset             = 1'b1;
  logic build_tree_finish = 1'b0;

  always #5 clk = ~clk;

  logic [NUM_SYMBOLS-1:0][COUNT_W-1:0] curr_count;
  logic [COUNT_W-1:0]                  total_count;
  logic                                build_tree_start;
  logic                                busy;
  logic                                invalid_seen;
  logic                                empty_err;
  state_t                              state_dbg;

  freq_count_if bus ();

  freq_count dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .build_tree_finish (build_tree_finish),
    .curr_count        (curr_count),
    .total_count       (total_count),
    .build_tree_start  (build_tree_start),
    .busy              (busy),
    .invalid_seen      (invalid_seen),
    .empty_err         (empty_err),
    .state_dbg         (state_dbg)
  );

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: offer one byte and hold it until the counter takes it.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    bus.data_last  = last;
    while (bus.data_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("send_timeout", 32'(bus.data_ready), 32'd1);
      bus.data_valid = 1'b0;
      bus.data_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;
  endtask

  // Release WAIT_TREE with a fresh rising edge of build_tree_finish.
  task automatic finish_pulse(input string tag);
    @(negedge clk);
    build_tree_finish = 1'b0;
    @(negedge clk);
    build_tree_finish = 1'b1;
    @(posedge clk);
    #1;
    check(tag, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;

    // reset state
    #1 reset = 1'b0;
    #2;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_ready", 32'(bus.data_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_total", 32'(total_count), 32'd0);
    check("rst_cnt65", 32'(curr_count[65]), 32'd0);
    check("rst_start", 32'(build_tree_start), 32'd0);
    check("rst_flags", {30'd0, invalid_seen, empty_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.data_ready), 32'd0);

    // frame "ABA"
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h41, 1'b1);
    check("aba_start", 32'(build_tree_start), 32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    check("aba_cnt65", 32'(curr_count[65]), exp_q.pop_front());
    check("aba_cnt66", 32'(curr_count[66]), exp_q.pop_front());
    check("aba_total", 32'(total_count), exp_q.pop_front());
    check("aba_cnt67", 32'(curr_count[67]), 32'd0);
    @(posedge clk);
    #1;
    check("aba_start_end", 32'(build_tree_start), 32'd0);
    check("aba_wait", 32'(state_dbg), 32'(WAIT_TREE));
    check("aba_busy", 32'(busy), 32'd1);

    // random traffic while waiting on the builder must be ignored
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.data_valid = 1'($urandom_range(0, 1));
      bus.data_in    = 8'($urandom_range(0, 255));
      bus.data_last  = 1'($urandom_range(0, 1));
      check("wt_ready", 32'(bus.data_ready), 32'd0);
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.data_last  = 1'b0;
    check("wt_cnt65", 32'(curr_count[65]), 32'd2);
    check("wt_total", 32'(total_count), 32'd3);
    check("wt_state", 32'(state_dbg), 32'(WAIT_TREE));

    // finish edge releases; counts held in IDLE
    finish_pulse("aba_release");
    repeat (3) @(negedge clk);
    check("idle_cnt65", 32'(curr_count[65]), 32'd2);
    check("idle_cnt66", 32'(curr_count[66]), 32'd1);
    check("idle_total", 32'(total_count), 32'd3);
    // a finish edge in IDLE changes nothing
    build_tree_finish = 1'b0;
    @(negedge clk);
    build_tree_finish = 1'b1;
    @(posedge clk);
    #1;
    check("idle_edge_ign", 32'(state_dbg), 32'(IDLE));

    // frame 0x80, 0x41 last, finish still high from before
    send_byte(8'h80, 1'b0);
    send_byte(8'h41, 1'b1);
    check("inv_start", 32'(build_tree_start), 32'd1);
    check("inv_seen", 32'(invalid_seen), 32'd1);
    check("inv_cnt65", 32'(curr_count[65]), 32'd1);
    check("inv_cnt66", 32'(curr_count[66]), 32'd0);
    check("inv_total", 32'(total_count), 32'd1);
    check("inv_empty", 32'(empty_err), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_high_wait", 32'(state_dbg), 32'(WAIT_TREE));
    @(negedge clk);
    build_tree_finish = 1'b0;
    @(posedge clk);
    #1;
    check("low_wait", 32'(state_dbg), 32'(WAIT_TREE));
    @(negedge clk);
    build_tree_finish = 1'b1;
    @(posedge clk);
    #1;
    check("rerise_idle", 32'(state_dbg), 32'(IDLE));

    // single 0xFF last: empty frame
    send_byte(8'hFF, 1'b1);
    check("empty_state", 32'(state_dbg), 32'(IDLE));
    check("empty_err", 32'(empty_err), 32'd1);
    check("empty_inv", 32'(invalid_seen), 32'd1);
    check("empty_start", 32'(build_tree_start), 32'd0);
    check("empty_total", 32'(total_count), 32'd0);
    check("empty_cnt65", 32'(curr_count[65]), 32'd0);
    @(posedge clk);
    #1;
    check("empty_start2", 32'(build_tree_start), 32'd0);

    // reset after 5 bytes
    build_tree_finish = 1'b0;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h43, 1'b0);
    send_byte(8'h44, 1'b0);
    check("mid_total", 32'(total_count), 32'd5);
    check("mid_cnt65", 32'(curr_count[65]), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_total", 32'(total_count), 32'd0);
    check("mid_rst_cnt65", 32'(curr_count[65]), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    check("mid_rst_start", 32'(build_tree_start), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_start", 32'(build_tree_start), 32'd0);
    end
    check("post_rst_idle", 32'(state_dbg), 32'(IDLE));

    // next frame counts from zero, back-to-back same symbol
    send_byte(8'h43, 1'b0);
    send_byte(8'h43, 1'b1);
    check("c_start", 32'(build_tree_start), 32'd1);
    check("c_cnt67", 32'(curr_count[67]), 32'd2);
    check("c_cnt65", 32'(curr_count[65]), 32'd0);
    check("c_total", 32'(total_count), 32'd2);
    finish_pulse("c_release");

    // saturation: 70000 x 0x20 then 0x20 last
    for (int i = 0; i < 70000; i++) send_byte(8'h20, 1'b0);
    send_byte(8'h20, 1'b1);
    check("sat_start", 32'(build_tree_start), 32'd1);
    check("sat_cnt32", 32'(curr_count[32]), 32'h0000FFFE);
    check("sat_total", 32'(total_count), 32'h0000FFFF);
    check("sat_cnt33", 32'(curr_count[33]), 32'd0);
    finish_pulse("sat_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_count.md
FREQ_COUNT -- requirements
Module: freq_count

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: data_in  in  8  input byte; data_valid  in  1  byte offered; data_last  in  1  offered byte ends frame.
REQ-003 SHALL have ports: data_ready  out  1  byte accepted when data_valid&&data_ready.
REQ-004 SHALL have ports: build_tree_finish  in  1  done flag from tree builder (may stay high).
REQ-005 SHALL have ports: curr_count  out  [127:0][15:0]  per-symbol count, index = data_in[6:0]; total_count  out  16  symbols counted in frame.
REQ-006 SHALL have ports: build_tree_start  out  1  one-cycle start to tree builder; busy  out  1  state!=IDLE.
REQ-007 SHALL have ports: invalid_seen  out  1  sticky, byte with bit7=1 in frame; empty_err  out  1  sticky, frame had no countable byte.

Function
REQ-008 SHALL implement states IDLE, CLEAR, COUNT, START, WAIT_TREE.
REQ-009 IDLE: data_ready=0; data_valid=1 -> CLEAR (byte not consumed).
REQ-010 CLEAR: one cycle; zero all curr_count, total_count, invalid_seen, empty_err; -> COUNT.
REQ-011 COUNT: data_ready=1; each accepted byte with bit7=0 increments curr_count[data_in[6:0]] by 1 in the cycle after acceptance.
REQ-012 Per-symbol count SHALL saturate at 16'hFFFE (16'hFFFF is the tree builder's end sentinel and never appears).
REQ-013 total_count SHALL increment with every counted byte, saturating at 16'hFFFF.
REQ-014 Accepted byte with bit7=1: no count change, invalid_seen<=1.
REQ-015 Accepted byte with data_last=1 SHALL be counted (if valid), then -> START if any byte counted in frame, else empty_err<=1 and -> IDLE.
REQ-016 START: build_tree_start=1 for exactly one cycle; data_ready=0; -> WAIT_TREE.
REQ-017 WAIT_TREE: data_ready=0; curr_count and total_count held stable; -> IDLE on rising edge of build_tree_finish (registered previous value), not on level.
REQ-018 Rising edge of build_tree_finish in any state other than WAIT_TREE SHALL be ignored.
REQ-019 Counts SHALL remain held in IDLE until next CLEAR.
REQ-020 data_valid without data_ready SHALL have no effect; data_last without acceptance SHALL be ignored.
REQ-021 Max throughput: one byte per cycle in COUNT, back-to-back same symbol counted correctly.
REQ-022 Latency: last byte accepted in cycle N -> build_tree_start high in cycle N+1.

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, all curr_count=0, total_count=0, build_tree_start=0, data_ready=0, busy=0, invalid_seen=0, empty_err=0, finish-edge register=0.
REQ-024 Reset mid-frame SHALL discard the frame; no build_tree_start issued.

Structure
REQ-025 Package huffman_pkg SHALL hold NUM_SYMBOLS=128, COUNT_W=16, COUNT_SAT=16'hFFFE, and the state enum.
REQ-026 Single module; no sub-module is natural.

Verification
REQ-027 Frame "ABA" (0x41,0x42,0x41 last) -> count[65]=2, count[66]=1, total=3, start pulse one cycle after last accept.
REQ-028 70000 bytes 0x20 then last -> count[32]=16'hFFFE, total=16'hFFFF, no wrap.
REQ-029 Frame 0x80,0x41 last -> invalid_seen=1, count[65]=1, total=1; single byte 0xFF last -> empty_err=1, no start, back to IDLE.
REQ-030 build_tree_finish held high from prior frame -> stays in WAIT_TREE until finish drops and re-rises.
REQ-031 reset asserted after 5 bytes of frame -> all counts 0, IDLE, no start; next frame counts from zero.
REQ-032 data_valid toggled randomly with data_ready low in WAIT_TREE -> counts unchanged.
